// File: rtl/uart_xcvr_param_if.sv
// Serial transceiver bus: transmit request/status, serial lines and receive results.
// The DUT attaches through the slave modport; the driving side uses master.
interface uart_xcvr_param_if #(
  parameter int DATA_W = 8
);
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic              serial_tx;
  logic              serial_rx;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_parity_err;
  logic              rx_frame_err;

  modport slave (
    input  tx_start, tx_data, serial_rx,
    output tx_busy, serial_tx, rx_data, rx_valid, rx_parity_err, rx_frame_err
  );

  modport master (
    output tx_start, tx_data, serial_rx,
    input  tx_busy, serial_tx, rx_data, rx_valid, rx_parity_err, rx_frame_err
  );
endinterface

// File: rtl/uart_xcvr_param.sv
// Parameterised UART transceiver: independent TX and RX engines sharing one bit-period
// definition, with optional odd/even parity and one or two transmitted stop bits.
module uart_xcvr_param #(
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_xcvr_param_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam bit            HAS_PAR  = (PARITY != 0);
  localparam bit            ODD_PAR  = (PARITY == 1);
  localparam bit            TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  // ---------------------------------------------------------------- TX engine
  state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_par_q, tx_par_d;
  logic              tx_stop2_q, tx_stop2_d;
  logic              tx_bit_end;
  logic              tx_line;
  logic              tx_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_stop2_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_stop2_q <= tx_stop2_d;
    end
  end

  assign tx_bit_end = (tx_cnt_q == CNT_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_stop2_d = tx_stop2_q;
    if (tx_state_q != S_IDLE) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    end
    unique case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (bus.tx_start) begin
          tx_state_d = S_START;
          tx_shift_d = bus.tx_data;
          tx_par_d   = ODD_PAR ? ~^bus.tx_data : ^bus.tx_data;
          tx_bit_d   = '0;
          tx_stop2_d = 1'b0;
        end
      end
      S_START: begin
        if (tx_bit_end) tx_state_d = S_DATA;
      end
      S_DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
          tx_bit_d   = tx_bit_q + 1'b1;
          if (tx_bit_q == BIT_LAST) tx_state_d = HAS_PAR ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (tx_bit_end) tx_state_d = S_STOP;
      end
      S_STOP: begin
        // With two stop bits the first period only arms the flag for a second pass.
        if (tx_bit_end) begin
          if (TWO_STOP && !tx_stop2_q) tx_stop2_d = 1'b1;
          else                         tx_state_d = S_IDLE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_busy = (tx_state_q != S_IDLE);
    tx_line = 1'b1;
    unique case (tx_state_q)
      S_START: tx_line = 1'b0;
      S_DATA:  tx_line = tx_shift_q[0];
      S_PAR:   tx_line = tx_par_q;
      default: tx_line = 1'b1;
    endcase
  end

  assign bus.tx_busy   = tx_busy;
  assign bus.serial_tx = tx_line;

  // ---------------------------------------------------------------- RX engine
  logic              rx_meta_q, rx_sync_q;
  state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              rx_parbit_q, rx_parbit_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_perr_q, rx_perr_d;
  logic              rx_ferr_q, rx_ferr_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_bit_end;
  logic              rx_par_calc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_parbit_q <= 1'b0;
      rx_data_q   <= '0;
      rx_perr_q   <= 1'b0;
      rx_ferr_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_meta_q   <= bus.serial_rx;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_parbit_q <= rx_parbit_d;
      rx_data_q   <= rx_data_d;
      rx_perr_q   <= rx_perr_d;
      rx_ferr_q   <= rx_ferr_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign rx_bit_end  = (rx_cnt_q == CNT_LAST);
  assign rx_par_calc = ODD_PAR ? ~^rx_shift_q : ^rx_shift_q;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_parbit_d = rx_parbit_q;
    rx_data_d   = rx_data_q;
    rx_perr_d   = rx_perr_q;
    rx_ferr_d   = rx_ferr_q;
    rx_valid_d  = 1'b0;
    unique case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = S_START;
      end
      S_START: begin
        // Half-period resample aligns all later samples to mid-bit and rejects glitches.
        if (rx_cnt_q == CNT_MID) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_bit_end) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_W-1:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == BIT_LAST) rx_state_d = HAS_PAR ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (rx_bit_end) begin
          rx_parbit_d = rx_sync_q;
          rx_state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_bit_end) begin
          rx_data_d  = rx_shift_q;
          rx_ferr_d  = ~rx_sync_q;
          rx_perr_d  = HAS_PAR && (rx_parbit_q != rx_par_calc);
          rx_valid_d = 1'b1;
          rx_state_d = S_IDLE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Scoreboard bench for two transceiver configurations: 8E1 with switchable loopback,
// and 7O2 permanently looped back.
module tb_uart_xcvr_param;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   vcnt_a = 0, vcnt_b = 0;
  int   vcyc_a = 0, vcyc_a_prev = 0;

  uart_xcvr_param_if #(.DATA_W(8)) ifa ();
  uart_xcvr_param_if #(.DATA_W(7)) ifb ();

  logic loop_en_a = 1'b1;
  logic rx_drv_a  = 1'b1;
  assign ifa.serial_rx = loop_en_a ? ifa.serial_tx : rx_drv_a;
  assign ifb.serial_rx = ifb.serial_tx;

  uart_xcvr_param #(.DATA_W(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  uart_xcvr_param #(.DATA_W(7), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(16)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  // Receive monitors: every rx_valid pops one expected frame.
  always @(negedge clk) begin
    if (ifa.rx_valid === 1'b1) begin
      vcnt_a++;
      vcyc_a_prev = vcyc_a;
      vcyc_a      = cyc;
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL rx_a_unexpected: got data=%h perr=%b ferr=%b, required no rx_valid",
                 ifa.rx_data, ifa.rx_parity_err, ifa.rx_frame_err);
      end else begin
        ea = q_a.pop_front();
        if ({ifa.rx_data, ifa.rx_parity_err, ifa.rx_frame_err} !== {ea.data[7:0], ea.perr, ea.ferr}) begin
          failures++;
          $display("FAIL rx_a_frame: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                   ifa.rx_data, ifa.rx_parity_err, ifa.rx_frame_err, ea.data[7:0], ea.perr, ea.ferr);
        end
      end
    end
    if (ifb.rx_valid === 1'b1) begin
      vcnt_b++;
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL rx_b_unexpected: got data=%h, required no rx_valid", ifb.rx_data);
      end else begin
        eb = q_b.pop_front();
        if ({ifb.rx_data, ifb.rx_parity_err, ifb.rx_frame_err} !== {eb.data[6:0], eb.perr, eb.ferr}) begin
          failures++;
          $display("FAIL rx_b_frame: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                   ifb.rx_data, ifb.rx_parity_err, ifb.rx_frame_err, eb.data[6:0], eb.perr, eb.ferr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [7:0] d, input bit expect_rx);
    ifa.tx_start = 1'b1;
    ifa.tx_data  = d;
    if (expect_rx) q_a.push_back(exp_t'{9'(d), 1'b0, 1'b0});
    tick();
    ifa.tx_start = 1'b0;
  endtask

  task automatic wait_idle_a(output int n);
    n = 0;
    while (ifa.tx_busy === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && t < 1000) begin
      t++;
      tick();
    end
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d/%0d frames outstanding, required 0/0", name, q_a.size(), q_b.size());
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    ifa.tx_start = 1'b1;
    ifa.tx_data  = 8'hFF;
    ifb.tx_start = 1'b1;
    ifb.tx_data  = 7'h55;
    repeat (3) tick();
    checks++;
    if ({ifa.tx_busy, ifa.serial_tx, ifa.rx_valid, ifa.rx_data, ifa.rx_parity_err, ifa.rx_frame_err} !== 13'b0_1_0_00000000_0_0) begin
      failures++;
      $display("FAIL reset_a: got busy=%b tx=%b valid=%b data=%h pe=%b fe=%b, required 0 1 0 00 0 0",
               ifa.tx_busy, ifa.serial_tx, ifa.rx_valid, ifa.rx_data, ifa.rx_parity_err, ifa.rx_frame_err);
    end
    checks++;
    if ({ifb.tx_busy, ifb.serial_tx, ifb.rx_valid, ifb.rx_data, ifb.rx_parity_err, ifb.rx_frame_err} !== 12'b0_1_0_0000000_0_0) begin
      failures++;
      $display("FAIL reset_b: got busy=%b tx=%b valid=%b data=%h pe=%b fe=%b, required 0 1 0 00 0 0",
               ifb.tx_busy, ifb.serial_tx, ifb.rx_valid, ifb.rx_data, ifb.rx_parity_err, ifb.rx_frame_err);
    end
    rst_n        = 1'b1;
    ifa.tx_start = 1'b0;
    ifb.tx_start = 1'b0;
    tick();
    checks++;
    if ({ifa.tx_busy, ifb.tx_busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_start_ignored: got busy a/b=%b%b, required 00", ifa.tx_busy, ifb.tx_busy);
    end
    repeat (4) tick();
  endtask

  task automatic test_basic();
    logic [7:0]  d  = 8'hA5;
    logic [10:0] bits;
    int n = 0;
    int v0 = vcnt_a;
    bits = {1'b1, ^d, d, 1'b0};
    start_a(d, 1'b1);
    while (ifa.tx_busy === 1'b1 && n < 2000) begin
      if (n % 16 == 8 && n / 16 < 11) begin
        checks++;
        if (ifa.serial_tx !== bits[n / 16]) begin
          failures++;
          $display("FAIL basic_bit%0d: got %b, required %b", n / 16, ifa.serial_tx, bits[n / 16]);
        end
      end
      n++;
      tick();
    end
    checks++;
    if (n != 176) begin
      failures++;
      $display("FAIL basic_busy_len: got %0d, required 176", n);
    end
    drain("basic");
    repeat (20) tick();
    checks++;
    if (vcnt_a - v0 != 1) begin
      failures++;
      $display("FAIL basic_valid_count: got %0d, required 1", vcnt_a - v0);
    end
  endtask

  task automatic test_ignore_busy();
    int m;
    int v0 = vcnt_a;
    start_a(8'h3C, 1'b1);
    repeat (49) tick();
    ifa.tx_start = 1'b1;
    ifa.tx_data  = 8'hFF;
    tick();
    ifa.tx_start = 1'b0;
    wait_idle_a(m);
    checks++;
    if (50 + m != 176) begin
      failures++;
      $display("FAIL ignore_busy_len: got %0d, required 176", 50 + m);
    end
    drain("ignore");
    repeat (200) tick();
    checks++;
    if (ifa.tx_busy !== 1'b0 || vcnt_a - v0 != 1) begin
      failures++;
      $display("FAIL ignore_single_frame: got busy=%b frames=%0d, required busy=0 frames=1",
               ifa.tx_busy, vcnt_a - v0);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start_a(8'h01, 1'b1);
    wait_idle_a(n);
    start_a(8'h80, 1'b1);
    checks++;
    if (ifa.tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: got busy=%b, required 1", ifa.tx_busy);
    end
    wait_idle_a(n);
    drain("b2b");
    checks++;
    if (vcyc_a - vcyc_a_prev != 177) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d, required 177", vcyc_a - vcyc_a_prev);
    end
    repeat (10) tick();
  endtask

  task automatic test_rx_errors();
    logic [7:0]  d = 8'h55;
    logic [10:0] bits;
    int v0;
    loop_en_a = 1'b0;
    rx_drv_a  = 1'b1;
    repeat (5) tick();
    v0 = vcnt_a;
    rx_drv_a = 1'b0;
    repeat (6) tick();
    rx_drv_a = 1'b1;
    repeat (40) tick();
    checks++;
    if (vcnt_a != v0) begin
      failures++;
      $display("FAIL rx_glitch: got %0d rx_valid, required 0", vcnt_a - v0);
    end
    bits = {1'b0, ~(^d), d, 1'b0};
    q_a.push_back(exp_t'{9'(d), 1'b1, 1'b1});
    for (int k = 0; k < 11; k++) begin
      rx_drv_a = bits[k];
      repeat (16) tick();
    end
    rx_drv_a = 1'b1;
    drain("rx_err");
    repeat (40) tick();
    checks++;
    if (vcnt_a - v0 != 1) begin
      failures++;
      $display("FAIL rx_err_count: got %0d, required 1", vcnt_a - v0);
    end
    loop_en_a = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int v0 = vcnt_a;
    start_a(8'hC3, 1'b0);
    repeat (79) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({ifa.serial_tx, ifa.tx_busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_mid_abort: got tx=%b busy=%b, required tx=1 busy=0", ifa.serial_tx, ifa.tx_busy);
    end
    repeat (200) tick();
    checks++;
    if (vcnt_a != v0) begin
      failures++;
      $display("FAIL reset_mid_no_rx: got %0d rx_valid, required 0", vcnt_a - v0);
    end
    start_a(8'h5A, 1'b1);
    wait_idle_a(n);
    drain("reset_mid");
    checks++;
    if (vcnt_a - v0 != 1) begin
      failures++;
      $display("FAIL reset_mid_recover: got %0d frames, required 1", vcnt_a - v0);
    end
  endtask

  task automatic test_param_b();
    logic [6:0]  d = 7'h7F;
    logic [10:0] bits;
    int n = 0;
    bits = {2'b11, ~(^d), d, 1'b0};
    ifb.tx_start = 1'b1;
    ifb.tx_data  = d;
    q_b.push_back(exp_t'{9'(d), 1'b0, 1'b0});
    tick();
    ifb.tx_start = 1'b0;
    while (ifb.tx_busy === 1'b1 && n < 2000) begin
      if (n % 16 == 8 && n / 16 < 11) begin
        checks++;
        if (ifb.serial_tx !== bits[n / 16]) begin
          failures++;
          $display("FAIL param_b_bit%0d: got %b, required %b", n / 16, ifb.serial_tx, bits[n / 16]);
        end
      end
      n++;
      tick();
    end
    checks++;
    if (n != 176) begin
      failures++;
      $display("FAIL param_b_busy_len: got %0d, required 176", n);
    end
    drain("param_b");
  endtask

  task automatic test_concurrent();
    int n;
    ifa.tx_start = 1'b1;
    ifa.tx_data  = 8'h96;
    ifb.tx_start = 1'b1;
    ifb.tx_data  = 7'h2A;
    q_a.push_back(exp_t'{9'h096, 1'b0, 1'b0});
    q_b.push_back(exp_t'{9'h02A, 1'b0, 1'b0});
    tick();
    ifa.tx_start = 1'b0;
    ifb.tx_start = 1'b0;
    checks++;
    if ({ifa.tx_busy, ifb.tx_busy} !== 2'b11) begin
      failures++;
      $display("FAIL concurrent_busy: got a/b=%b%b, required 11", ifa.tx_busy, ifb.tx_busy);
    end
    wait_idle_a(n);
    drain("concurrent");
    repeat (10) tick();
  endtask

  initial begin
    ifa.tx_start = 1'b0;
    ifa.tx_data  = '0;
    ifb.tx_start = 1'b0;
    ifb.tx_data  = '0;
    test_reset();
    test_basic();
    test_ignore_busy();
    test_back_to_back();
    test_rx_errors();
    test_reset_mid_frame();
    test_param_b();
    test_concurrent();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_xcvr_param.md
UART_XCVR_PARAM -- requirements
Module: uart_xcvr_param

Interface
REQ-001 The block SHALL have one clock and synchronous active-low reset, named clk and rst_n; rst_n is sampled only on posedge clk.
REQ-002 Parameter DATA_W, default 8: data bits per frame, legal range 5..9.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1: stop bits per transmitted frame, 1 or 2.
REQ-005 Parameter CLKS_PER_BIT, default 16: clk cycles per bit period, minimum 4.
REQ-006 clk  input  1  system clock.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 tx_start  input  1  transmit request, one-cycle pulse.
REQ-009 tx_data  input  DATA_W  byte to transmit, sampled with tx_start.
REQ-010 tx_busy  output  1  high while a TX frame is in progress.
REQ-011 serial_tx  output  1  serial line out, idle high.
REQ-012 serial_rx  input  1  asynchronous serial line in.
REQ-013 rx_data  output  DATA_W  last received data word.
REQ-014 rx_valid  output  1  one-cycle pulse, received frame complete.
REQ-015 rx_parity_err  output  1  parity mismatch, qualified by rx_valid.
REQ-016 rx_frame_err  output  1  stop bit sampled low, qualified by rx_valid.

Function
REQ-017 TX FSM states: IDLE, START, DATA, PAR, STOP; PAR SHALL be skipped when PARITY = 0.
REQ-018 tx_start SHALL be accepted only in IDLE with tx_busy low; tx_start while tx_busy is high SHALL be ignored, with no effect on the frame in flight.
REQ-019 On acceptance, tx_data SHALL be latched; starting the next cycle, tx_busy = 1 and serial_tx = 0 for CLKS_PER_BIT cycles.
REQ-020 Data bits SHALL be sent LSB first, each held CLKS_PER_BIT cycles.
REQ-021 Parity bit: even = XOR of data bits; odd = inverted XOR.
REQ-022 STOP SHALL drive serial_tx = 1 for STOP_BITS*CLKS_PER_BIT cycles; tx_busy SHALL fall on the cycle the FSM re-enters IDLE.
REQ-023 tx_busy SHALL be high for exactly CLKS_PER_BIT*(1+DATA_W+(PARITY?1:0)+STOP_BITS) cycles per frame.
REQ-024 A tx_start in the first cycle tx_busy is low SHALL be accepted, giving back-to-back frames with no idle gap beyond that one cycle.
REQ-025 serial_rx SHALL pass through a 2-flop synchronizer; all RX decisions use the synchronized value.
REQ-026 RX FSM states: IDLE, START, DATA, PAR, STOP; a synchronized low in IDLE SHALL enter START.
REQ-027 In START, the line SHALL be resampled after CLKS_PER_BIT/2 cycles: low continues to DATA, high returns to IDLE (glitch reject, no rx_valid).
REQ-028 Each subsequent bit SHALL be sampled at mid-bit, CLKS_PER_BIT cycles after the previous sample; data is assembled LSB first.
REQ-029 RX SHALL check only the first stop bit regardless of STOP_BITS.
REQ-030 At the stop-bit sample, rx_data, rx_parity_err and rx_frame_err SHALL update and rx_valid SHALL pulse one cycle; the FSM then returns to IDLE.
REQ-031 rx_valid SHALL pulse even when an error flag is set; rx_data and the error flags SHALL hold until the next rx_valid.
REQ-032 rx_frame_err SHALL be set when the stop sample is 0; rx_parity_err SHALL be set on mismatch and SHALL always be 0 when PARITY = 0.
REQ-033 Bit-period counters SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL wrap to 0 at CLKS_PER_BIT-1.
REQ-034 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-035 While rst_n = 0 at posedge clk: serial_tx = 1, tx_busy = 0, rx_valid = 0, rx_data = 0, both error flags 0, synchronizer flops = 1, both FSMs IDLE, counters 0.
REQ-036 Reset asserted mid-frame SHALL abort both frames within one cycle; tx_start coincident with rst_n = 0 SHALL be ignored.

Verification (DATA_W=8, PARITY=2, STOP_BITS=1, CLKS_PER_BIT=16, serial_tx looped to serial_rx unless noted)
REQ-037 tx_start with tx_data=0xA5 -> tx_busy high 176 cycles, serial_tx sequence 0,1,0,1,0,0,1,0,1,0,1; one rx_valid, rx_data=0xA5, both error flags 0.
REQ-038 tx_start 0x3C, then tx_start 0xFF at cycle 50 -> second request ignored; exactly one frame received, rx_data=0x3C.
REQ-039 Back-to-back 0x01 then 0x80, each tx_start in the first cycle tx_busy is low -> two rx_valid pulses 177 cycles apart, data 0x01 then 0x80.
REQ-040 Loop broken: drive serial_rx low for 6 cycles -> no rx_valid; then inject frame 0x55 with bad parity and stop=0 -> rx_valid with rx_data=0x55, rx_parity_err=1, rx_frame_err=1.
REQ-041 rst_n low for 1 cycle at cycle 80 of a 0xC3 frame -> next cycle serial_tx=1, tx_busy=0, no rx_valid; a new frame 0x5A is then received cleanly.
REQ-042 Repeat REQ-037 with PARITY=1, STOP_BITS=2, DATA_W=7, tx_data=0x7F -> tx_busy high 176 cycles, parity bit=0, rx_data=0x7F, no errors.
